// File: rtl/inst_loader_if.sv
// Program-stream and instruction-memory write bundle for the instruction loader.
// The stream source (or test driver) uses master; the loader uses slave.
interface inst_loader_if;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
    );
endinterface

// File: rtl/inst_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory
// as 32-bit words, holding the CPU until the load completes successfully.
module inst_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    inst_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR
    } state_t;

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_t      state_q;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [1:0]  bcnt_q;
    logic [7:0]  csum_q;
    logic [23:0] word_q;
    logic        byte_ready_q;
    logic        wr_en_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic        cpu_hold_q;
    logic        done_q;
    logic        err_q;

    logic        accept;
    logic [15:0] len_d;
    logic [15:0] idx_d;
    logic [7:0]  csum_d;

    assign accept = bus.byte_valid & byte_ready_q;
    assign len_d  = {len_q[15:8], bus.byte_in};
    assign idx_d  = idx_q + 16'd1;
    assign csum_d = csum_q + bus.byte_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            bcnt_q       <= '0;
            csum_q       <= '0;
            word_q       <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            wr_data_q    <= '0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        state_q      <= LEN_HI;
                        byte_ready_q <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                        idx_q        <= '0;
                        bcnt_q       <= '0;
                        csum_q       <= '0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= bus.byte_in;
                        state_q     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_q <= len_d;
                        if (32'(len_d) > DEPTH_U) begin
                            state_q      <= ERR;
                            err_q        <= 1'b1;
                            byte_ready_q <= 1'b0;
                        end else if (len_d == 16'd0) begin
                            state_q <= CSUM;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    // Input is paused for the write cycle so the index (and the
                    // move to CSUM) always follows the wr_en pulse.
                    if (wr_en_q) begin
                        idx_q        <= idx_d;
                        byte_ready_q <= 1'b1;
                        if (idx_d == len_q) begin
                            state_q <= CSUM;
                        end
                    end else if (accept) begin
                        csum_q <= csum_d;
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            wr_data_q    <= {word_q, bus.byte_in};
                            wr_addr_q    <= BASE_ADDR + 32'({idx_q, 2'b00});
                            wr_en_q      <= 1'b1;
                            byte_ready_q <= 1'b0;
                        end else begin
                            word_q <= {word_q[15:0], bus.byte_in};
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        byte_ready_q <= 1'b0;
                        if (bus.byte_in == csum_q) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    byte_ready_q <= 1'b0;
                    cpu_hold_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: nominal, bad checksum, oversize, empty,
// backpressure and mid-load reset, with writes captured from the memory port.
module tb_inst_loader;
    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    inst_loader_if ifc ();

    inst_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifc.wr_en === 1'b1) begin
            wa_q.push_back(ifc.wr_addr);
            wd_q.push_back(ifc.wr_data);
            $display("[TB] write addr=%h data=%h", ifc.wr_addr, ifc.wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %h", tag, got);
        end
    endtask

    function automatic logic [31:0] wr_at(input bit is_data, input int i);
        if (is_data) return (i < wd_q.size()) ? wd_q[i] : 32'hxxxx_xxxx;
        return (i < wa_q.size()) ? wa_q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    // Offer one byte until accepted; with gaps, valid is randomly withheld.
    task automatic send(input logic [7:0] b, input bit gaps);
        bit acc = 1'b0;
        bit rdy;
        int n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 1) == 1) begin
                ifc.byte_valid = 1'b0;
                ifc.byte_in    = 8'($urandom);
            end else begin
                ifc.byte_valid = 1'b1;
                ifc.byte_in    = b;
            end
            rdy = ifc.byte_ready;
            @(posedge clk);
            acc = ifc.byte_valid && rdy;
            n++;
        end
        #1 ifc.byte_valid = 1'b0;
        if (!acc) check("byte_accept_timeout", 32'(b), 32'hffff_ffff);
    endtask

    task automatic send_stream(input logic [7:0] s[], input bit gaps);
        foreach (s[i]) send(s[i], gaps);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] s_nom[];
        logic [7:0] s_bad[];
        logic [7:0] s_big[];
        logic [7:0] s_emp[];
        logic [7:0] s_bp[];
        logic [7:0] s_one[];
        int n_before;

        s_nom = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h01, 8'h34, 8'h02, 8'h00, 8'h02, 8'h6E};
        s_bad = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h01, 8'h34, 8'h02, 8'h00, 8'h02, 8'h6F};
        s_big = '{8'h04, 8'h01};
        s_emp = '{8'h00, 8'h00, 8'h00};
        s_bp  = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h2E};
        s_one = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};

        ifc.start      = 1'b0;
        ifc.byte_in    = 8'h00;
        ifc.byte_valid = 1'b0;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_byte_ready", 32'(ifc.byte_ready), 32'd0);
        check("rst_wr_en",      32'(ifc.wr_en),      32'd0);
        check("rst_wr_addr",    ifc.wr_addr,         32'h0);
        check("rst_wr_data",    ifc.wr_data,         32'h0);
        check("rst_cpu_hold",   32'(ifc.cpu_hold),   32'd0);
        check("rst_done_err",   {30'd0, ifc.done, ifc.err}, 32'd0);

        // Nominal two-word load
        clear_writes();
        pulse_start();
        check("nom_hold_loading", 32'(ifc.cpu_hold), 32'd1);
        check("nom_ready_loading", 32'(ifc.byte_ready), 32'd1);
        send_stream(s_nom, 1'b0);
        check("nom_nwr",   32'(wa_q.size()), 32'd2);
        check("nom_addr0", wr_at(0, 0), 32'h0000_0000);
        check("nom_data0", wr_at(1, 0), 32'h3401_0001);
        check("nom_addr1", wr_at(0, 1), 32'h0000_0004);
        check("nom_data1", wr_at(1, 1), 32'h3402_0002);
        check("nom_done",  32'(ifc.done), 32'd1);
        check("nom_err",   32'(ifc.err), 32'd0);
        check("nom_hold",  32'(ifc.cpu_hold), 32'd0);
        check("nom_ready", 32'(ifc.byte_ready), 32'd0);
        check("nom_wr_hold_addr", ifc.wr_addr, 32'h0000_0004);

        // Bad checksum
        clear_writes();
        pulse_start();
        check("bad_done_cleared", 32'(ifc.done), 32'd0);
        send_stream(s_bad, 1'b0);
        check("bad_nwr",   32'(wa_q.size()), 32'd2);
        check("bad_data1", wr_at(1, 1), 32'h3402_0002);
        check("bad_err",   32'(ifc.err), 32'd1);
        check("bad_done",  32'(ifc.done), 32'd0);
        check("bad_hold",  32'(ifc.cpu_hold), 32'd1);

        // Oversize length N = 1025, checked right after the second byte
        clear_writes();
        pulse_start();
        check("big_err_cleared", 32'(ifc.err), 32'd0);
        send(s_big[0], 1'b0);
        send(s_big[1], 1'b0);
        check("big_err",   32'(ifc.err), 32'd1);
        check("big_ready", 32'(ifc.byte_ready), 32'd0);
        repeat (4) @(negedge clk);
        check("big_nwr",   32'(wa_q.size()), 32'd0);
        check("big_done",  32'(ifc.done), 32'd0);

        // Empty load
        clear_writes();
        pulse_start();
        send_stream(s_emp, 1'b0);
        check("emp_done", 32'(ifc.done), 32'd1);
        check("emp_err",  32'(ifc.err), 32'd0);
        check("emp_nwr",  32'(wa_q.size()), 32'd0);

        // Three-word load with random valid gaps
        clear_writes();
        pulse_start();
        send_stream(s_bp, 1'b1);
        check("bp_nwr",   32'(wa_q.size()), 32'd3);
        check("bp_addr0", wr_at(0, 0), 32'h0000_0000);
        check("bp_data0", wr_at(1, 0), 32'h1122_3344);
        check("bp_addr1", wr_at(0, 1), 32'h0000_0004);
        check("bp_data1", wr_at(1, 1), 32'h5566_7788);
        check("bp_addr2", wr_at(0, 2), 32'h0000_0008);
        check("bp_data2", wr_at(1, 2), 32'h99AA_BBCC);
        check("bp_done",  32'(ifc.done), 32'd1);

        // Reset after 5 data bytes, with start asserted on the same edge
        clear_writes();
        pulse_start();
        for (int i = 0; i < 7; i++) send(s_bp[i], 1'b0);
        repeat (2) @(negedge clk);
        n_before = wa_q.size();
        check("rst_mid_nwr_before", 32'(n_before), 32'd1);
        rst       = 1'b1;
        ifc.start = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        ifc.start = 1'b0;
        check("rst_mid_hold",  32'(ifc.cpu_hold), 32'd0);
        check("rst_mid_ready", 32'(ifc.byte_ready), 32'd0);
        check("rst_mid_addr",  ifc.wr_addr, 32'h0);
        @(negedge clk);
        ifc.byte_valid = 1'b1;
        ifc.byte_in    = 8'h66;
        repeat (8) @(negedge clk);
        ifc.byte_valid = 1'b0;
        check("rst_mid_nwr_after", 32'(wa_q.size()), 32'(n_before));
        check("rst_mid_hold_idle", 32'(ifc.cpu_hold), 32'd0);

        clear_writes();
        pulse_start();
        send_stream(s_one, 1'b0);
        check("one_nwr",  32'(wa_q.size()), 32'd1);
        check("one_addr", wr_at(0, 0), 32'h0000_0000);
        check("one_data", wr_at(1, 0), 32'hDEAD_BEEF);
        check("one_done", 32'(ifc.done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024; meaning: maximum number of 32-bit words the instruction memory can hold.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h00000000; meaning: byte address at which the first loaded word is written.
REQ-003 SHALL have port clk, input, 1 bit; meaning: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; meaning: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit; meaning: begin a load session.
REQ-006 SHALL have port byte_in, input, 8 bits; meaning: incoming program stream byte.
REQ-007 SHALL have port byte_valid, input, 1 bit; meaning: byte_in is valid this cycle.
REQ-008 SHALL have port byte_ready, output, 1 bit; meaning: loader accepts byte_in this cycle.
REQ-009 SHALL have port wr_en, output, 1 bit; meaning: instruction-memory write strobe.
REQ-010 SHALL have port wr_addr, output, 32 bits; meaning: byte address of the write, word-aligned.
REQ-011 SHALL have port wr_data, output, 32 bits; meaning: instruction word to write.
REQ-012 SHALL have port cpu_hold, output, 1 bit; meaning: keeps the CPU stalled and instruction fetch disabled while loading.
REQ-013 SHALL have port done, output, 1 bit; meaning: load completed and checksum matched.
REQ-014 SHALL have port err, output, 1 bit; meaning: load aborted (bad length or checksum).

Function
REQ-015 SHALL accept a byte only on a cycle where byte_valid and byte_ready are both 1; byte_valid without byte_ready has no effect.
REQ-016 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
REQ-017 SHALL drive byte_ready = 1 only in LEN_HI, LEN_LO, DATA and CSUM.
REQ-018 SHALL move from IDLE, DONE or ERR to LEN_HI on start = 1; in this transition it clears done, err, the word index, the byte count and the checksum.
REQ-019 SHALL ignore start while in LEN_HI, LEN_LO, DATA or CSUM.
REQ-020 SHALL take the stream format as: 16-bit word count N (high byte first), then N words of 4 bytes each (most significant byte first), then 1 checksum byte.
REQ-021 SHALL, on the accepted LEN_LO byte, go to ERR if N > DEPTH, to CSUM if N = 0, and otherwise to DATA.
REQ-022 SHALL assemble words in DATA using a 2-bit byte counter; when the 4th byte is accepted, it SHALL register wr_data and wr_addr = BASE_ADDR + 4*index (modulo 2^32), then pulse wr_en for exactly one cycle on the next cycle.
REQ-023 SHALL keep wr_en = 0 at all other times; wr_addr and wr_data SHALL hold their last values while wr_en = 0.
REQ-024 SHALL increment the word index after each write and go to CSUM once N words have been written; the first CSUM byte SHALL NOT be accepted before the last wr_en pulse has been issued.
REQ-025 SHALL keep the checksum as the 8-bit sum, modulo 256, of all accepted data bytes; length and checksum bytes are excluded.
REQ-026 SHALL, on the accepted CSUM byte, go to DONE with done = 1 if the byte equals the checksum, and otherwise go to ERR with err = 1.
REQ-027 SHALL drive cpu_hold = 1 in every state except IDLE and DONE.
REQ-028 SHALL hold done and err in DONE and ERR until the next start or rst; done and err SHALL never both be 1.

Reset
REQ-029 SHALL, with rst = 1 at a clock edge, enter IDLE and set byte_ready = 0, wr_en = 0, wr_addr = BASE_ADDR, wr_data = 0, cpu_hold = 0, done = 0, err = 0, and clear all counters and the checksum.
REQ-030 SHALL abort any load when rst is asserted mid-operation, with no further wr_en pulses; words already written are not recalled.
REQ-031 SHALL give rst priority over start when both are 1 on the same edge.

Verification
REQ-032 SHALL be verified with a nominal load: start; bytes 00 02 34 01 00 01 34 02 00 02 6E -> wr_en pulses at 0x0 with 34010001 and at 0x4 with 34020002, then done = 1, err = 0, cpu_hold = 0.
REQ-033 SHALL be verified with a bad checksum: the same stream with last byte 6F -> both writes occur, then err = 1, done = 0, cpu_hold = 1.
REQ-034 SHALL be verified with an oversize length: start; bytes 04 01 (N = 1025) -> ERR immediately after the second byte, no wr_en, byte_ready = 0.
REQ-035 SHALL be verified with an empty load: start; bytes 00 00 00 -> done = 1 and no wr_en.
REQ-036 SHALL be verified with backpressure and reset: byte_valid toggled randomly during a 3-word load gives the same writes; rst asserted after 5 data bytes -> IDLE, no further wr_en, and a new start with a 1-word stream loads at BASE_ADDR.
